// File: rtl/demux2x4_buf.sv
// demux2x4_buf: registered 1-to-2 demultiplexer with a one-entry buffer per lane.
// A nibble source is steered into lane 0 or lane 1. Each lane drains through its
// own valid/ready handshake.
// Optional feature macro: DEMUX2X4_BUF_AUTO_SEL_EN. When it is defined, an
// internal toggle bit picks the lane (alternating 0,1,0,...) and sel is ignored.
//
// Handshake semantics (all ports): a transfer happens on a rising edge where
// valid & ready are both high. A producer must not make valid depend on ready.
// in_ready is combinational from g, the target lane and that lane's state and
// consumer ready. It never looks at in_valid.
module demux2x4_buf #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_d,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             sel,
   input  logic             g,
   output logic [WIDTH-1:0] out0_d,
   output logic [WIDTH-1:0] out1_d,
   output logic             out0_valid,
   output logic             out1_valid,
   input  logic             out0_ready,
   input  logic             out1_ready,
   output logic             lane_sel,
   output logic [CNT_W-1:0] acc_cnt
);

   logic [1:0]       full;
   logic [WIDTH-1:0] data0;
   logic [WIDTH-1:0] data1;
   logic [1:0]       drain;
   logic             accept;
   logic             acc0;
   logic             acc1;

`ifdef DEMUX2X4_BUF_AUTO_SEL_EN
   logic t;

   // Toggle pointer: advances only on an accept, so a stalled lane holds it.
   always_ff @(posedge clk) begin
      if (rst) begin
         t <= 1'b0;
      end else if (accept) begin
         t <= ~t;
      end
   end

   assign lane_sel = t;
`else
   assign lane_sel = sel;
`endif

   // Handshake decode: a lane can take a new entry when it is empty, or when
   // it is being drained in the same cycle.
   always_comb begin
      drain[0] = full[0] & out0_ready;
      drain[1] = full[1] & out1_ready;
      in_ready = ~g & (~full[lane_sel] | drain[lane_sel]);
      accept   = in_valid & in_ready;
      acc0     = accept & ~lane_sel;
      acc1     = accept &  lane_sel;
   end

   // Lane occupancy. An accept wins over a drain on the same lane because the
   // new entry replaces the one the consumer just took.
   always_ff @(posedge clk) begin
      if (rst) begin
         full <= 2'b00;
      end else begin
         if (acc0) begin
            full[0] <= 1'b1;
         end else if (drain[0]) begin
            full[0] <= 1'b0;
         end
         if (acc1) begin
            full[1] <= 1'b1;
         end else if (drain[1]) begin
            full[1] <= 1'b0;
         end
      end
   end

   // Lane payload registers. They load only on an accept into that lane.
   always_ff @(posedge clk) begin
      if (rst) begin
         data0 <= '0;
         data1 <= '0;
      end else begin
         if (acc0) begin
            data0 <= in_d;
         end
         if (acc1) begin
            data1 <= in_d;
         end
      end
   end

   // Accepted-transfer counter. It wraps naturally at 2^CNT_W.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_cnt <= '0;
      end else if (accept) begin
         acc_cnt <= acc_cnt + 1'b1;
      end
   end

   // Lane outputs. Data is forced to zero while the lane is empty.
   always_comb begin
      out0_valid = full[0];
      out1_valid = full[1];
      out0_d     = full[0] ? data0 : '0;
      out1_d     = full[1] ? data1 : '0;
   end

endmodule

// File: tb/tb_demux2x4_buf.sv
// tb_demux2x4_buf: randomized and directed bench for demux2x4_buf.
// Reference model: each lane is a queue of pending nibbles. The counter is a
// plain integer taken modulo 2^CNT_W.
module tb_demux2x4_buf;

   localparam int W  = 4;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [W-1:0]  in_d = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          sel = 1'b0;
   logic          g = 1'b0;
   logic [W-1:0]  out0_d;
   logic [W-1:0]  out1_d;
   logic          out0_valid;
   logic          out1_valid;
   logic          out0_ready = 1'b0;
   logic          out1_ready = 1'b0;
   logic          lane_sel;
   logic [CW-1:0] acc_cnt;

   demux2x4_buf #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_d       (in_d),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .sel        (sel),
      .g          (g),
      .out0_d     (out0_d),
      .out1_d     (out1_d),
      .out0_valid (out0_valid),
      .out1_valid (out1_valid),
      .out0_ready (out0_ready),
      .out1_ready (out1_ready),
      .lane_sel   (lane_sel),
      .acc_cnt    (acc_cnt)
   );

`ifdef DEMUX2X4_BUF_AUTO_SEL_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   // Clock generation.
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;

   // Scoreboard: one expected queue per lane, plus the counter and the
   // alternating pointer.
   logic [W-1:0] exp_q0[$];
   logic [W-1:0] exp_q1[$];
   int           exp_cnt = 0;
   bit           exp_tog = 1'b0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Driver: applies one cycle of stimulus, checks every output against the
   // model, then advances the model across the rising edge.
   task automatic cycle(input bit r, input bit v, input logic [W-1:0] d, input bit s,
                        input bit gg, input bit r0, input bit r1);
      bit tgt;
      bit has0;
      bit has1;
      bit er;
      @(negedge clk);
      rst = r; in_valid = v; in_d = d; sel = s; g = gg;
      out0_ready = r0; out1_ready = r1;
      #1;
      tgt  = AUTO ? exp_tog : s;
      has0 = (exp_q0.size() != 0);
      has1 = (exp_q1.size() != 0);
      er   = !gg && (tgt ? (!has1 || r1) : (!has0 || r0));
      check("in_ready",   {31'b0, in_ready},   {31'b0, er});
      check("lane_sel",   {31'b0, lane_sel},   {31'b0, tgt});
      check("out0_valid", {31'b0, out0_valid}, {31'b0, has0});
      check("out1_valid", {31'b0, out1_valid}, {31'b0, has1});
      check("out0_d", {28'b0, out0_d}, has0 ? {28'b0, exp_q0[0]} : 32'd0);
      check("out1_d", {28'b0, out1_d}, has1 ? {28'b0, exp_q1[0]} : 32'd0);
      check("acc_cnt", {24'b0, acc_cnt}, exp_cnt);
      @(posedge clk);
      if (r) begin
         exp_q0.delete();
         exp_q1.delete();
         exp_cnt = 0;
         exp_tog = 1'b0;
      end else begin
         if (has0 && r0) void'(exp_q0.pop_front());
         if (has1 && r1) void'(exp_q1.pop_front());
         if (v && er) begin
            if (tgt) exp_q1.push_back(d);
            else     exp_q0.push_back(d);
            exp_cnt = (exp_cnt + 1) % (1 << CW);
            exp_tog = ~exp_tog;
         end
      end
   endtask

   task automatic do_reset();
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      // Reset state
      do_reset();
      #1;
      check("rst_out0_valid", {31'b0, out0_valid}, 32'd0);
      check("rst_acc_cnt", {24'b0, acc_cnt}, 32'd0);

      // Single accept into lane 0, then a second beat to the same full lane
      cycle(1'b0, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      check("t1_out0_d", {28'b0, out0_d}, 32'hA);
      check("t1_out1_valid", {31'b0, out1_valid}, 32'd0);
      check("t1_acc_cnt", {24'b0, acc_cnt}, 32'd1);
      cycle(1'b0, 1'b1, 4'hB, 1'b0, 1'b0, 1'b0, 1'b0);

      // Same-lane accept while draining
      do_reset();
      cycle(1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0);
      #1;
      check("t2_out0_d", {28'b0, out0_d}, 32'h5);
      check("t2_out0_valid", {31'b0, out0_valid}, 32'd1);

      // g blocks accepts, but lane 1 still drains
      cycle(1'b0, 1'b1, 4'hC, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 4'h9, 1'b1, 1'b1, 1'b0, 1'b1);
      #1;
      check("t3_out1_valid", {31'b0, out1_valid}, 32'd0);
      check("t3_acc_cnt", {24'b0, acc_cnt}, 32'd3);

      // Accept into lane 1 while lane 0 drains
      cycle(1'b0, 1'b1, 4'h7, 1'b1, 1'b0, 1'b1, 1'b0);
      #1;
      check("t4_out1_d", {28'b0, out1_d}, 32'h7);
      check("t4_out0_valid", {31'b0, out0_valid}, 32'd0);

      // Counter wrap: 257 accepts with both consumers always ready
      do_reset();
      for (int i = 0; i < 257; i++) begin
         cycle(1'b0, 1'b1, W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               1'b0, 1'b1, 1'b1);
      end
      #1;
      check("wrap_acc_cnt", {24'b0, acc_cnt}, 32'd1);
      // Reset asserted in the middle of the stream
      cycle(1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1);
      #1;
      check("midrst_acc_cnt", {24'b0, acc_cnt}, 32'd0);
      check("midrst_valid", {30'b0, out1_valid, out0_valid}, 32'd0);

`ifdef DEMUX2X4_BUF_AUTO_SEL_EN
      // Alternating lanes with sel held at 1
      do_reset();
      cycle(1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 1'b1, 1'b1);
      #1;
      check("auto_lane0_a", {28'b0, out0_d}, 32'h1);
      cycle(1'b0, 1'b1, 4'h2, 1'b1, 1'b0, 1'b1, 1'b1);
      #1;
      check("auto_lane1", {28'b0, out1_d}, 32'h2);
      cycle(1'b0, 1'b1, 4'h3, 1'b1, 1'b0, 1'b1, 1'b1);
      #1;
      check("auto_lane0_b", {28'b0, out0_d}, 32'h3);
      // Stall lane 1: the pointer must hold and in_ready must drop
      cycle(1'b0, 1'b1, 4'h4, 1'b1, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 4'h5, 1'b1, 1'b0, 1'b1, 1'b0);
      #1;
      check("auto_stall_lane", {31'b0, lane_sel}, 32'd1);
      check("auto_stall_ready", {31'b0, in_ready}, 32'd0);
`endif

      // Random traffic with occasional reset
      do_reset();
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 63) == 0),
               1'($urandom_range(0, 1)),
               W'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
